// File: rtl/sp_ram_master_if.sv
// Request/response channel between a host (or BIST sequencer) and sp_ram_master.
//
// Signals:
//   req_valid  host -> master  request present
//   req_ready  master -> host  master can accept a request this cycle
//   req_we     host -> master  1 = write, 0 = read
//   req_addr   host -> master  request address
//   req_wdata  host -> master  write data (ignored for reads)
//   rsp_valid  master -> host  one-cycle pulse, rsp_rdata valid
//   rsp_rdata  master -> host  captured read data, held until the next capture
//
// Modports:
//   master : the requesting side (drives req_*)
//   slave  : sp_ram_master itself (accepts requests, returns responses)
interface sp_ram_master_if #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDRWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DATAWIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sp_ram_master.sv
// Host-side initiator for a single-port RAM with a shared bidirectional data
// bus. Turns a valid/ready request stream into timed RAM cycles, owns bus
// direction (including the release cycle after every read) and returns read
// data on a one-cycle response strobe.
//
// Ports:
//   clk       single clock, all state changes on posedge
//   rst       synchronous reset, active-high
//   req       request/response channel (sp_ram_master_if.slave)
//   mem_addr  RAM address
//   mem_cs    RAM chip select
//   mem_we    RAM write enable
//   mem_data  shared RAM data bus, driven only while writing
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released, waiting for a request
// WRITE | cs=we=1, bus driven with registered write data
// READ  | cs=1, we=0, RAM samples the address; latency counter loaded
// WAIT  | cs=1, we=0, counting down until read data is valid on the bus
// TURN  | cs=0, bus released, rsp_valid pulse; guards write-after-read
module sp_ram_master #(
    parameter int ADDRWIDTH  = 4,
    parameter int DATAWIDTH  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sp_ram_master_if.slave       req,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic                 mem_cs,
    output logic                 mem_we,
    inout  wire  [DATAWIDTH-1:0] mem_data
);

    // A 3-bit counter covers 1..7; anything else must stop the build rather
    // than silently wrap.
    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
        $error("sp_ram_master: RD_LATENCY must be in 1..7");
    end

    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        TURN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2:0]           cnt;
    logic [2:0]           cnt_next;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 ready;
    logic                 accept;
    logic                 capture;
    logic                 drive;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_addr <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                mem_addr <= req.req_addr;
                wdata_q  <= req.req_wdata;
            end
            if (capture) begin
                rdata_q <= mem_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        // Ready is qualified with rst so nothing is accepted while reset is
        // held, yet the first cycle after release already accepts.
        ready      = !rst && (state == IDLE || state == WRITE);
        accept     = req.req_valid && ready;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        drive      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req.req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_cs = 1'b1;
                mem_we = 1'b1;
                drive  = 1'b1;
                if (accept) begin
                    state_next = req.req_we ? WRITE : READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                mem_cs     = 1'b1;
                cnt_next   = LAT_INIT;
                state_next = WAIT;
            end
            WAIT: begin
                mem_cs   = 1'b1;
                cnt_next = cnt - 3'd1;
                // Counter reaches zero at this edge: data is on the bus now.
                if (cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = TURN;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_data      = drive ? wdata_q : {DATAWIDTH{1'bz}};
    assign req.req_ready = ready;
    assign req.rsp_valid = (state == TURN);
    assign req.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sp_ram_master.sv
// Bench for sp_ram_master: two instances (read latency 1 and 3), each with a
// behavioural RAM model on its shared data bus. Expected data comes from a
// per-instance array of written values; expected timing from the read
// latency rule (response RD_LATENCY+1 cycles after the accept edge).
module tb_sp_ram_master;

    logic clk;
    logic rst;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Request drivers and observed outputs, one slot per instance.
    logic       rv    [2];
    logic       rwe   [2];
    logic [3:0] ra    [2];
    logic [7:0] rd    [2];
    logic       rdy   [2];
    logic       rsp_v [2];
    logic [7:0] rsp_d [2];
    logic       cs    [2];
    logic       we    [2];
    logic [3:0] maddr [2];
    logic [7:0] bus_o [2];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        localparam int LAT = (g == 0) ? 1 : 3;

        sp_ram_master_if #(.ADDRWIDTH(4), .DATAWIDTH(8)) ifc ();
        wire  [7:0] bus;
        logic [3:0] m_addr;
        logic       m_cs;
        logic       m_we;
        logic [7:0] ram  [16];
        logic [7:0] pipe [LAT];

        sp_ram_master #(
            .ADDRWIDTH (4),
            .DATAWIDTH (8),
            .RD_LATENCY(LAT)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (ifc),
            .mem_addr(m_addr),
            .mem_cs  (m_cs),
            .mem_we  (m_we),
            .mem_data(bus)
        );

        assign ifc.req_valid = rv[g];
        assign ifc.req_we    = rwe[g];
        assign ifc.req_addr  = ra[g];
        assign ifc.req_wdata = rd[g];
        assign rdy[g]        = ifc.req_ready;
        assign rsp_v[g]      = ifc.rsp_valid;
        assign rsp_d[g]      = ifc.rsp_rdata;
        assign cs[g]         = m_cs;
        assign we[g]         = m_we;
        assign maddr[g]      = m_addr;
        assign bus_o[g]      = bus;

        // RAM: writes at the edge ending a cs=we=1 cycle; read data emerges
        // LAT edges after the sampling edge and is driven only while cs=1, we=0.
        always @(posedge clk) begin
            if (m_cs && m_we) ram[m_addr] <= bus;
            pipe[0] <= ram[m_addr];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus = (m_cs && !m_we) ? pipe[LAT-1] : 8'bz;
    end

    int p_cnt0 = 0;
    int p_cnt1 = 0;
    always @(negedge clk) begin
        if (rsp_v[0]) p_cnt0 <= p_cnt0 + 1;
        if (rsp_v[1]) p_cnt1 <= p_cnt1 + 1;
    end

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_mem [2][16];
    bit         written [2][16];

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int s, input bit w, input logic [3:0] a,
                         input logic [7:0] d, output int acc);
        int n;
        n = 0;
        rv[s] = 1'b1; rwe[s] = w; ra[s] = a; rd[s] = d;
        while (!rdy[s] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready_wait", 32'(n < 50), 1);
        @(posedge clk); #1;
        acc   = cyc;
        rv[s] = 1'b0;
    endtask

    task automatic do_write(input int s, input logic [3:0] a, input logic [7:0] d);
        int acc;
        issue(s, 1'b1, a, d, acc);
        chk("wr_cs",   cs[s],    1);
        chk("wr_we",   we[s],    1);
        chk("wr_addr", maddr[s], a);
        chk("wr_bus",  bus_o[s], d);
        exp_mem[s][a] = d;
        written[s][a] = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called at #1 after the accept edge of a read; waits for the response.
    task automatic finish_read(input int s, input int acc, input logic [7:0] exp, input string tag);
        int n;
        int busy;
        n = 0; busy = 0;
        while (!rsp_v[s] && n < 40) begin
            if (cs[s] && !we[s]) busy++;
            @(posedge clk); #1; n++;
        end
        chk($sformatf("%s_timeout", tag), 32'(n < 40), 1);
        chk($sformatf("%s_data", tag), rsp_d[s], exp);
        chk($sformatf("%s_lat", tag), cyc - acc, lat_of(s) + 1);
        chk($sformatf("%s_busy", tag), busy, lat_of(s) + 1);
        chk($sformatf("%s_turn_cs", tag), cs[s], 0);
        chk($sformatf("%s_turn_rdy", tag), rdy[s], 0);
        @(posedge clk); #1;
        chk($sformatf("%s_width", tag), rsp_v[s], 0);
    endtask

    task automatic do_read(input int s, input logic [3:0] a, input string tag);
        int acc;
        issue(s, 1'b0, a, 8'h00, acc);
        finish_read(s, acc, exp_mem[s][a], tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int snap;
        logic [7:0] d;
        logic [3:0] a;

        for (int s = 0; s < 2; s++) begin
            rv[s] = 1'b0; rwe[s] = 1'b0; ra[s] = '0; rd[s] = '0;
            for (int i = 0; i < 16; i++) begin
                exp_mem[s][i] = '0;
                written[s][i] = 1'b0;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs",    cs[0],    0);
        chk("rst_we",    we[0],    0);
        chk("rst_addr",  maddr[0], 0);
        chk("rst_ready", rdy[0],   0);
        chk("rst_rspv",  rsp_v[0], 0);
        chk("rst_rdata", rsp_d[0], 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", rdy[0], 1);

        // Prime a known nonzero rsp_rdata before the mid-read reset.
        do_write(0, 4'd5, 8'h77);
        do_read(0, 4'd5, "pre_rd5");

        // Reset during WAIT: the pending read is discarded.
        snap = p_cnt0;
        issue(0, 1'b0, 4'd5, 8'h00, acc);
        chk("mid_read_cs", cs[0], 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cs",    cs[0],    0);
        chk("midrst_we",    we[0],    0);
        chk("midrst_addr",  maddr[0], 0);
        chk("midrst_rspv",  rsp_v[0], 0);
        chk("midrst_rdata", rsp_d[0], 0);
        chk("midrst_ready", rdy[0],   0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", rdy[0], 1);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_pulse", p_cnt0 - snap, 0);
        chk("midrst_idle_cs", cs[0], 0);

        // Back-to-back write burst over the whole address space.
        rv[0] = 1'b1; rwe[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            ra[0] = 4'(i); rd[0] = d;
            chk("burst_ready", rdy[0], 1);
            @(posedge clk); #1;
            chk("burst_cs",   cs[0],    1);
            chk("burst_we",   we[0],    1);
            chk("burst_addr", maddr[0], i);
            chk("burst_bus",  bus_o[0], d);
            exp_mem[0][i] = d;
            written[0][i] = 1'b1;
        end
        rv[0] = 1'b0;
        @(posedge clk); #1;
        chk("burst_end_cs", cs[0], 0);
        chk("burst_end_addr_hold", maddr[0], 15);

        // Read sweep.
        snap = p_cnt0;
        for (int i = 0; i < 16; i++) do_read(0, 4'(i), "sweep");
        #5;
        chk("sweep_pulses", p_cnt0 - snap, 16);

        // Write-after-read through the TURN cycle.
        do_read(0, 4'd3, "war_rd");
        chk("war_idle_cs", cs[0], 0);
        do_write(0, 4'd3, 8'hA5);
        do_read(0, 4'd3, "war_reread");

        // Read immediately following a write to the same address.
        rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 4'd9; rd[0] = 8'h3C;
        chk("raw_ready_idle", rdy[0], 1);
        @(posedge clk); #1;
        chk("raw_wr_we", we[0], 1);
        chk("raw_ready_write", rdy[0], 1);
        exp_mem[0][9] = 8'h3C;
        written[0][9] = 1'b1;
        rwe[0] = 1'b0;
        @(posedge clk); #1;
        acc   = cyc;
        rv[0] = 1'b0;
        chk("raw_read_cs",   cs[0],    1);
        chk("raw_read_we",   we[0],    0);
        chk("raw_read_addr", maddr[0], 9);
        finish_read(0, acc, 8'h3C, "raw");

        // Latency-3 instance.
        do_write(1, 4'd0, 8'($urandom));
        do_read(1, 4'd0, "lat3_rd0");

        // Random mixed traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 20; k++) begin
                a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1 || !written[s][a]) begin
                    do_write(s, a, 8'($urandom));
                end else begin
                    do_read(s, a, "rand_rd");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
